// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with NZVC
// flag register, PC update command and a memory-handshake timeout watchdog.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        carry_out,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        immSel,
  output logic        ALUsrc,
  output logic [2:0]  ALUop,
  output logic [3:0]  LDURBsel,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [3:0]  flags,
  output logic        instr_done,
  output logic        error
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_ADDI, I_ADDS, I_SUBS, I_LDUR, I_LDURB,
    I_STUR, I_STURB, I_B, I_CBZ, I_BLT
  } iclass_t;

  state_t             state, state_nx;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   mem_cnt, mem_cnt_nx;
  iclass_t            icls;

  logic is_load, is_store, is_mem, is_byte, is_branch, is_flagset;
  logic mem_timeout;
  logic ex_reg2loc, ex_immsel, ex_alusrc;
  logic [2:0] ex_aluop;
  logic unused_ir_bits;

  // Register-index and immediate fields are consumed by the datapath, not here
  assign unused_ir_bits = ^ir[20:5];

  // Opcode classification of the latched instruction
  always_comb begin
    icls = I_ILL;
    if (ir[31:22] == 10'b1001000100)                          icls = I_ADDI;
    else if (ir[31:21] == 11'b10101011000)                    icls = I_ADDS;
    else if (ir[31:21] == 11'b11101011000)                    icls = I_SUBS;
    else if (ir[31:21] == 11'b11111000010)                    icls = I_LDUR;
    else if (ir[31:21] == 11'b00111000010)                    icls = I_LDURB;
    else if (ir[31:21] == 11'b11111000000)                    icls = I_STUR;
    else if (ir[31:21] == 11'b00111000000)                    icls = I_STURB;
    else if (ir[31:26] == 6'b000101)                          icls = I_B;
    else if (ir[31:24] == 8'b10110100)                        icls = I_CBZ;
    else if (ir[31:24] == 8'b01010100 && ir[4:0] == 5'b01011) icls = I_BLT;
  end

  assign is_load    = (icls == I_LDUR) || (icls == I_LDURB);
  assign is_store   = (icls == I_STUR) || (icls == I_STURB);
  assign is_mem     = is_load || is_store;
  assign is_byte    = (icls == I_LDURB) || (icls == I_STURB);
  assign is_branch  = (icls == I_B) || (icls == I_CBZ) || (icls == I_BLT);
  assign is_flagset = (icls == I_ADDS) || (icls == I_SUBS);

  assign mem_timeout = (mem_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Operand/ALU controls set up in EXEC and held through MEM and WB
  always_comb begin
    ex_reg2loc = 1'b0;
    ex_immsel  = 1'b0;
    ex_alusrc  = 1'b0;
    ex_aluop   = 3'b000;
    unique case (icls)
      I_ADDI: begin
        ex_alusrc = 1'b1;
        ex_immsel = 1'b1;
        ex_aluop  = 3'b010;
      end
      I_ADDS: begin
        ex_reg2loc = 1'b1;
        ex_aluop   = 3'b010;
      end
      I_SUBS: begin
        ex_reg2loc = 1'b1;
        ex_aluop   = 3'b011;
      end
      I_LDUR, I_LDURB, I_STUR, I_STURB: begin
        ex_alusrc = 1'b1;
        ex_aluop  = 3'b010;
      end
      default: ;
    endcase
  end

  // State, latched instruction, flags and MEM wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      flags   <= 4'b0000;
      mem_cnt <= '0;
    end else begin
      state   <= state_nx;
      mem_cnt <= mem_cnt_nx;
      if (state == S_FETCH && instr_valid) ir <= instr;
      if (state == S_EXEC && is_flagset) flags <= {negative, zero, overflow, carry_out};
    end
  end

  // Next state and datapath control outputs
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    Reg2Loc     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    immSel      = 1'b0;
    ALUsrc      = 1'b0;
    ALUop       = 3'b000;
    LDURBsel    = 4'd0;
    pc_en       = 1'b0;
    pc_sel      = 2'b00;
    instr_done  = 1'b0;
    error       = 1'b0;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      Reg2Loc = ex_reg2loc;
      immSel  = ex_immsel;
      ALUsrc  = ex_alusrc;
      ALUop   = ex_aluop;
    end

    unique case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        state_nx = (icls == I_ILL) ? S_ERROR : S_EXEC;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_en      = 1'b1;
          instr_done = 1'b1;
          if (icls == I_B)        pc_sel = 2'b01;
          else if (icls == I_CBZ) pc_sel = zero ? 2'b10 : 2'b00;
          else                    pc_sel = (flags[3] != flags[1]) ? 2'b10 : 2'b00;
          state_nx = S_FETCH;
        end else if (is_mem) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MemWrite = is_store;
        LDURBsel = is_byte ? 4'd1 : 4'd8;
        if (mem_ready) begin
          if (is_store) begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_nx   = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (mem_timeout) begin
          state_nx = S_ERROR;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = is_load;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_nx = S_ERROR;
      end
    endcase
  end

  // Wait counter runs only while staying in MEM; any exit clears it
  always_comb begin
    mem_cnt_nx = '0;
    if (state == S_MEM && state_nx == S_MEM) mem_cnt_nx = mem_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle model comparison plus directed instruction runs.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 4;

  typedef enum int {C_ADDI, C_ADDS, C_SUBS, C_LDUR, C_LDURB, C_STUR, C_STURB,
                    C_B, C_CBZ, C_BLT, C_ILL} cls_t;

  localparam logic [31:0] PMASK [10] = '{32'hFFC0_0000, 32'hFFE0_0000, 32'hFFE0_0000,
                                         32'hFFE0_0000, 32'hFFE0_0000, 32'hFFE0_0000,
                                         32'hFFE0_0000, 32'hFC00_0000, 32'hFF00_0000,
                                         32'hFF00_001F};
  localparam logic [31:0] PVAL  [10] = '{32'h9100_0000, 32'hAB00_0000, 32'hEB00_0000,
                                         32'hF840_0000, 32'h3840_0000, 32'hF800_0000,
                                         32'h3800_0000, 32'h1400_0000, 32'hB400_0000,
                                         32'h5400_000B};

  localparam logic [31:0] W_ADDI  = 32'h9100_1401;
  localparam logic [31:0] W_ADDS  = 32'hAB02_0023;
  localparam logic [31:0] W_SUBS  = 32'hEB02_0023;
  localparam logic [31:0] W_LDUR  = 32'hF840_0041;
  localparam logic [31:0] W_LDURB = 32'h3840_0041;
  localparam logic [31:0] W_STUR  = 32'hF800_0041;
  localparam logic [31:0] W_STURB = 32'h3800_0041;
  localparam logic [31:0] W_B     = 32'h1400_0010;
  localparam logic [31:0] W_CBZ   = 32'hB400_0040;
  localparam logic [31:0] W_BLT   = 32'h5400_004B;
  localparam logic [31:0] W_BEQ   = 32'h5400_0040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic        zero, negative, overflow, carry_out;
  logic        mem_ready, mem_req;
  logic        Reg2Loc, RegWrite, MemWrite, MemToReg, immSel, ALUsrc;
  logic [2:0]  ALUop;
  logic [3:0]  LDURBsel;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [3:0]  flags;
  logic        instr_done, error;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .negative(negative), .overflow(overflow),
    .carry_out(carry_out), .mem_ready(mem_ready), .mem_req(mem_req), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemToReg(MemToReg), .immSel(immSel),
    .ALUsrc(ALUsrc), .ALUop(ALUop), .LDURBsel(LDURBsel), .pc_en(pc_en), .pc_sel(pc_sel),
    .flags(flags), .instr_done(instr_done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic cls_t classify(input logic [31:0] w);
    for (int i = 0; i < 10; i++)
      if ((w & PMASK[i]) == PVAL[i]) return cls_t'(i);
    return C_ILL;
  endfunction

  function automatic bit is_ld(input cls_t c); return c == C_LDUR || c == C_LDURB; endfunction
  function automatic bit is_st(input cls_t c); return c == C_STUR || c == C_STURB; endfunction
  function automatic bit is_br(input cls_t c); return c == C_B || c == C_CBZ || c == C_BLT; endfunction

  // Model: cycle index within the current instruction (1 = accepting fetch cycle)
  int          m_k    = 1;
  cls_t        m_cls  = C_ILL;
  bit          m_err  = 1'b0;
  bit          m_wb   = 1'b0;
  int          m_memn = 0;
  logic [3:0]  m_flags = 4'b0000;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k <= 1; m_err <= 1'b0; m_wb <= 1'b0; m_memn <= 0; m_flags <= 4'b0000; m_cls <= C_ILL;
    end else if (!m_err) begin
      if (m_k == 1) begin
        if (instr_valid) begin m_cls <= classify(instr); m_k <= 2; end
      end else if (m_k == 2) begin
        if (m_cls == C_ILL) m_err <= 1'b1; else m_k <= 3;
      end else if (m_k == 3) begin
        if (m_cls == C_ADDS || m_cls == C_SUBS) m_flags <= {negative, zero, overflow, carry_out};
        if (is_br(m_cls)) m_k <= 1;
        else begin m_k <= 4; m_wb <= !(is_ld(m_cls) || is_st(m_cls)); m_memn <= 0; end
      end else if (m_wb) begin
        m_k <= 1; m_wb <= 1'b0;
      end else if (mem_ready) begin
        if (is_st(m_cls)) m_k <= 1;
        else begin m_k <= m_k + 1; m_wb <= 1'b1; end
      end else begin
        m_memn <= m_memn + 1;
        m_k    <= m_k + 1;
        if (m_memn + 1 == int'(TMO)) m_err <= 1'b1;
      end
    end
  end

  function automatic logic [23:0] exp_vec();
    logic ir_, req, r2l, rw, mw, m2r, imm, src, pen, done, er;
    logic [2:0] op;
    logic [3:0] sz;
    logic [1:0] ps;
    {ir_, req, r2l, rw, mw, m2r, imm, src, pen, done, er} = '0;
    op = 3'b000; sz = 4'd0; ps = 2'b00;
    if (m_err) er = 1'b1;
    else if (m_k == 1) ir_ = 1'b1;
    else if (m_k >= 3) begin
      case (m_cls)
        C_ADDI: begin src = 1'b1; imm = 1'b1; op = 3'b010; end
        C_ADDS: begin r2l = 1'b1; op = 3'b010; end
        C_SUBS: begin r2l = 1'b1; op = 3'b011; end
        C_LDUR, C_LDURB, C_STUR, C_STURB: begin src = 1'b1; op = 3'b010; end
        default: ;
      endcase
      if (m_k == 3) begin
        if (is_br(m_cls)) begin
          pen = 1'b1; done = 1'b1;
          if (m_cls == C_B)        ps = 2'b01;
          else if (m_cls == C_CBZ) ps = zero ? 2'b10 : 2'b00;
          else                     ps = (m_flags[3] != m_flags[1]) ? 2'b10 : 2'b00;
        end
      end else if (m_wb) begin
        rw = 1'b1; m2r = is_ld(m_cls); pen = 1'b1; done = 1'b1;
      end else begin
        req = 1'b1; mw = is_st(m_cls);
        sz  = (m_cls == C_LDURB || m_cls == C_STURB) ? 4'd1 : 4'd8;
        if (mem_ready && is_st(m_cls)) begin pen = 1'b1; done = 1'b1; end
      end
    end
    return {ir_, req, r2l, rw, mw, m2r, imm, src, op, sz, pen, ps, m_flags, done, er};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Issue one instruction from a FETCH cycle and follow it to retire or error
  task automatic run_instr(input logic [31:0] w, input int rdy_at, input bit hold,
                           output int lat, output int nreq, output int nwr, output int nen,
                           output logic [1:0] ps, output bit es);
    int c;
    bit done;
    lat = 0; nreq = 0; nwr = 0; nen = 0; ps = 2'b11; es = 1'b0; done = 1'b0;
    instr = w; instr_valid = 1'b1;
    c = 1;
    while (!done && c <= 40) begin
      mem_ready = (c == rdy_at);
      @(negedge clk);
      if (mem_req) nreq++;
      if (MemWrite) nwr++;
      if (pc_en || RegWrite || MemWrite) nen++;
      if (error) begin es = 1'b1; done = 1'b1; end
      if (instr_done) begin lat = c; ps = pc_sel; done = 1'b1; end
      tick();
      if (!hold) instr_valid = 1'b0;
      c++;
    end
    mem_ready = 1'b0; instr_valid = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL run_bound: no retire or error within %0d cycles, one required", c - 1);
    end
  endtask

  initial begin
    int lat, nreq, nwr, nen;
    logic [1:0] ps;
    bit es;

    reset_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_ready = 1'b0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0; carry_out = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("cycle_outputs",
            {8'h00, instr_ready, mem_req, Reg2Loc, RegWrite, MemWrite, MemToReg, immSel, ALUsrc,
             ALUop, LDURBsel, pc_en, pc_sel, flags, instr_done, error},
            {8'h00, exp_vec()});
        chk("regwrite_memwrite_exclusive", {31'd0, RegWrite & MemWrite}, 32'd0);
      end
    join_none

    repeat (3) tick();
    @(negedge clk);
    chk("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    tick();
    reset_n = 1'b1;

    run_instr(W_ADDI, 0, 1'b1, lat, nreq, nwr, nen, ps, es);
    chk("addi_latency", lat, 4);
    chk("addi_no_mem_req", nreq, 0);
    @(negedge clk);
    chk("addi_next_fetch", {31'd0, instr_ready}, 32'd1);
    tick();

    negative = 1'b1;
    run_instr(W_SUBS, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("subs_latency", lat, 4);
    chk("subs_flags_n1v0", {28'd0, flags}, 32'b1000);
    run_instr(W_BLT, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("blt_taken_latency", lat, 3);
    chk("blt_taken_pc_sel", {30'd0, ps}, 32'b10);

    overflow = 1'b1;
    run_instr(W_SUBS, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("subs_flags_n1v1", {28'd0, flags}, 32'b1010);
    run_instr(W_BLT, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("blt_not_taken_pc_sel", {30'd0, ps}, 32'b00);

    negative = 1'b0; zero = 1'b1; overflow = 1'b0; carry_out = 1'b1;
    run_instr(W_ADDS, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("adds_flags", {28'd0, flags}, 32'b0101);
    negative = 1'b1; zero = 1'b0; carry_out = 1'b0;
    run_instr(W_ADDI, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("addi_keeps_flags", {28'd0, flags}, 32'b0101);
    run_instr(W_BLT, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("blt_uses_stored_flags", {30'd0, ps}, 32'b00);
    negative = 1'b0;

    zero = 1'b1;
    run_instr(W_CBZ, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("cbz_taken_pc_sel", {30'd0, ps}, 32'b10);
    zero = 1'b0;
    run_instr(W_CBZ, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("cbz_not_taken_pc_sel", {30'd0, ps}, 32'b00);
    run_instr(W_B, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("b_latency", lat, 3);
    chk("b_pc_sel", {30'd0, ps}, 32'b01);

    run_instr(W_LDURB, 7, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("ldurb_latency", lat, 8);
    chk("ldurb_mem_req_cycles", nreq, 4);
    chk("ldurb_no_memwrite", nwr, 0);
    run_instr(W_LDUR, 4, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("ldur_latency", lat, 5);
    chk("ldur_mem_req_cycles", nreq, 1);
    run_instr(W_STUR, 4, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("stur_latency", lat, 4);
    chk("stur_memwrite_cycles", nwr, 1);
    chk("stur_pc_sel", {30'd0, ps}, 32'b00);
    run_instr(W_STURB, 5, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("sturb_latency", lat, 5);
    chk("sturb_memwrite_cycles", nwr, 2);

    instr = W_STUR; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("abort_store_in_mem", {31'd0, MemWrite}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    chk("abort_no_done", {30'd0, instr_done, pc_en}, 32'd0);
    tick();
    reset_n = 1'b1;

    run_instr(W_STUR, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("timeout_error", {31'd0, es}, 32'd1);
    chk("timeout_memwrite_cycles", nwr, 4);
    chk("timeout_mem_req_cycles", nreq, 4);
    chk("timeout_no_retire", lat, 0);
    instr = W_ADDI; instr_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("error_sticky", {31'd0, error}, 32'd1);
    chk("error_not_ready", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    tick();
    do_reset();

    run_instr(32'h0000_0000, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("illegal_zero_error", {31'd0, es}, 32'd1);
    chk("illegal_zero_no_enables", nen, 0);
    do_reset();
    run_instr(W_BEQ, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("illegal_bcond_error", {31'd0, es}, 32'd1);
    do_reset();

    run_instr(W_ADDI, 0, 1'b0, lat, nreq, nwr, nen, ps, es);
    chk("addi_after_reset_latency", lat, 4);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 64-bit LEGv8 datapath (register file, ALU, data memory). It accepts one instruction per fetch handshake, steps it through FETCH/DECODE/EXEC/MEM/WB, and drives the datapath control lines in each state. It also holds the NZVC flag register and produces the PC update command. Memory accesses use a variable-latency handshake with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, maximum number of MEM-state cycles to wait for mem_ready before entering ERROR (legal range 1..255).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  32  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  controller accepts instr; high only in FETCH
zero, negative, overflow, carry_out  in  1 each  live ALU flags
mem_ready  in  1  data memory completed the access
mem_req  out  1  data memory access request
Reg2Loc  out  1  1 = Ab from Rm; 0 = Ab from Rd
RegWrite  out  1  register file write enable
MemWrite  out  1  data memory write enable
MemToReg  out  1  1 = Dw from memory
immSel  out  1  1 = Imm12 path; 0 = DAddr9 path
ALUsrc  out  1  1 = immediate operand
ALUop  out  3  000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
LDURBsel  out  4  transfer size: 8 = doubleword, 1 = byte
pc_en  out  1  one-cycle pulse that commits the next PC
pc_sel  out  2  00 PC+4, 01 PC+SE(imm26)<<2, 10 PC+SE(imm19)<<2
flags  out  4  stored {N,Z,V,C}
instr_done  out  1  one-cycle retire pulse
error  out  1  sticky error

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERROR. Asynchronous reset (reset_n=0) → FETCH, flags=0, timeout counter=0, latched instr=0. All outputs are 0 during reset except instr_ready=1.
- FETCH: instr_ready=1. On instr_valid=1, latch instr and go to DECODE. Otherwise stay.
- DECODE: decode the latched opcode. Unrecognised opcode → ERROR. Otherwise → EXEC.
- Opcodes:
  - ADDI [31:22]=1001000100
  - ADDS [31:21]=10101011000
  - SUBS [31:21]=11101011000
  - LDUR 11111000010
  - LDURB 00111000010
  - STUR 11111000000
  - STURB 00111000000
  - B [31:26]=000101
  - CBZ [31:24]=10110100
  - B.cond [31:24]=01010100 with [4:0]=01011 (LT); any other cond is illegal.
- EXEC control by instruction:
  - ADDI: ALUsrc=1, immSel=1, ALUop=010.
  - ADDS/SUBS: Reg2Loc=1, ALUop=010/011. Latch {negative,zero,overflow,carry_out} into flags at the end of EXEC.
  - Load/store: ALUsrc=1, immSel=0, ALUop=010, Reg2Loc=0.
  - CBZ: Reg2Loc=0, ALUop=000.
- Next state after EXEC:
  - ALU instructions → WB.
  - Loads/stores → MEM.
  - Branches retire in EXEC with pc_en=1, instr_done=1, then → FETCH.
    - B: pc_sel=01.
    - CBZ: pc_sel=10 if zero=1, else 00.
    - B.LT: pc_sel=10 if flags N≠V, else 00.
- MEM:
  - mem_req=1 and the EXEC address controls are held.
  - Stores: MemWrite=1 for every MEM cycle.
  - LDURBsel = 1 for byte ops, 8 for doubleword ops.
  - The counter increments each MEM cycle without mem_ready.
  - mem_ready=1: stores retire (pc_en, pc_sel=00, instr_done) → FETCH; loads → WB.
  - If the counter reaches MEM_TIMEOUT without mem_ready → ERROR.
  - mem_ready in the same cycle the counter hits the limit counts as success.
  - The counter clears on leaving MEM.
- WB: RegWrite=1. MemToReg=1 for loads. Address/ALU controls are held from EXEC. pc_en=1, pc_sel=00, instr_done=1 → FETCH.
- ERROR: all enables 0, instr_ready=0, error=1. Exit only via reset.
- Minimum latencies, counted as cycles from the accepting FETCH cycle:
  - Branch: 3.
  - ALU instruction: 4.
  - Store: 4+k.
  - Load: 5+k.
  - k = extra MEM wait cycles.
- RegWrite and MemWrite are never high in the same cycle.
- Flags change only on ADDS/SUBS.
- Reset asserted mid-instruction aborts it with no pc_en and no writes.

Test Plan:
- ADDI X1,X0,#5 (0x91001401), instr_valid held high → DECODE, EXEC (ALUop=010, ALUsrc=1, immSel=1), WB (RegWrite=1); pc_en and instr_done pulse in cycle 4; next FETCH in cycle 5.
- SUBS with ALU flags N=1,V=0, then B.LT (0x5400004B) → flags=1000 after SUBS; B.LT retires with pc_sel=10 in its EXEC cycle. Repeat with N=V → pc_sel=00.
- LDURB, mem_ready delayed 3 cycles → mem_req high for 4 cycles, LDURBsel=1, MemWrite=0; WB has MemToReg=1, RegWrite=1; total latency 8.
- STUR with mem_ready never asserted, MEM_TIMEOUT=4 → MemWrite high for 4 cycles, then ERROR; error=1 and instr_ready=0 until reset_n=0.
- Illegal opcode 0x00000000 → ERROR after DECODE; no RegWrite, MemWrite or pc_en ever asserted.
- reset_n pulsed low during the MEM state of a store → immediate FETCH, MemWrite=0, flags=0, no instr_done.
